// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the 19-bit CPU fetch path.
package fetch_unit_pkg;

  localparam int unsigned WORD_SIZE = 19;
  localparam int unsigned ADDR_SIZE = 20;

  // Register-load target codes shared with the control unit.
  localparam logic [2:0] LOAD_PC    = 3'd0;
  localparam logic [2:0] LOAD_IR    = 3'd1;
  localparam logic [2:0] LOAD_REG_A = 3'd2;
  localparam logic [2:0] LOAD_REG_B = 3'd3;
  localparam logic [2:0] LOAD_REG_C = 3'd4;

  localparam logic [ADDR_SIZE-1:0] FETCH_RESET_PC = 20'h00000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FULL
  } fetch_state_t;

  // Word-addressed increment; wraps silently at the top of the address space.
  function automatic logic [ADDR_SIZE-1:0] pc_next(input logic [ADDR_SIZE-1:0] pc);
    return pc + ADDR_SIZE'(1);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, load has priority over increment.
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_value,
  input  logic                 inc,
  output logic [ADDR_SIZE-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc_next(pc);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding memory reads, IR handoff.
// Optional stall counter port enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] RESET_PC = FETCH_RESET_PC
`ifdef FETCH_STALL_CNT_EN
  ,
  parameter int unsigned STALL_CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en,
  input  logic                 load_en,
  input  logic [2:0]           load_select,
  input  logic [ADDR_SIZE-1:0] load_data,
  output logic                 mem_req_valid,
  output logic [ADDR_SIZE-1:0] mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [WORD_SIZE-1:0] mem_rsp_data,
  output logic                 ir_valid,
  output logic [WORD_SIZE-1:0] ir_data,
  output logic [ADDR_SIZE-1:0] ir_pc,
  input  logic                 ir_ready,
  output logic                 busy
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  fetch_state_t         state, state_next;
  logic [ADDR_SIZE-1:0] pc;
  logic [ADDR_SIZE-1:0] req_pc;
  logic                 drop, drop_next;
  logic                 redirect;
  logic                 pc_inc;
  logic                 capture;

  assign redirect = load_en && (load_select == LOAD_PC);

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (redirect),
    .load_value(load_data),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // A redirect never blocks an accept/response already on the bus; it only
  // marks the in-flight word for discard via the drop flag.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    pc_inc     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && fetch_en) state_next = REQ;
      end
      REQ: begin
        if (mem_req_ready) begin
          state_next = WAIT;
          if (redirect) drop_next = 1'b1;
          else          pc_inc    = 1'b1;
        end
      end
      WAIT: begin
        if (redirect) begin
          if (mem_rsp_valid) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end else if (mem_rsp_valid) begin
          if (drop) begin
            drop_next  = 1'b0;
            state_next = fetch_en ? REQ : IDLE;
          end else begin
            capture    = 1'b1;
            state_next = FULL;
          end
        end
      end
      FULL: begin
        if (redirect || ir_ready) state_next = fetch_en ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc <= '0;
    end else if (state == REQ && mem_req_ready) begin
      req_pc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_data <= '0;
      ir_pc   <= '0;
    end else if (capture) begin
      ir_data <= mem_rsp_data;
      ir_pc   <= req_pc;
    end
  end

  assign ir_valid      = (state == FULL);
  assign mem_req_valid = (state == REQ);
  assign mem_req_addr  = pc;
  assign busy          = (state == WAIT) || ir_valid || drop;

`ifdef FETCH_STALL_CNT_EN
  logic stall_cond;

  assign stall_cond = (state == REQ && !mem_req_ready) ||
                      (state == WAIT && !mem_rsp_valid) ||
                      (ir_valid && !ir_ready);

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      stall_cnt <= '0;
    end else if (stall_cond && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 19-bit CPU; owns the program counter (PC).
- Issues single-outstanding read requests to instruction memory and captures each returned 19-bit word into the instruction register (IR).
- Presents IR plus its PC to the downstream decode/control stage over a valid/ready handshake.
- Accepts PC redirects from the control unit through the shared register-load interface (load_select = LOAD_PC).

Parameters:
- RESET_PC, 20'h00000, PC value loaded on reset.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- fetch_en  in  1  permits new fetch requests
- load_en  in  1  register-load strobe from control
- load_select  in  3  register-load target code; only LOAD_PC is acted on
- load_data  in  20  redirect target address
- mem_req_valid  out  1  fetch request valid
- mem_req_addr  out  20  fetch address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  response valid, in order, one cycle per response
- mem_rsp_data  in  19  fetched instruction word
- ir_valid  out  1  IR holds an instruction for decode
- ir_data  out  19  instruction register
- ir_pc  out  20  address of ir_data
- ir_ready  in  1  decode consumes IR
- busy  out  1  request outstanding or IR full

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, pc=RESET_PC, mem_req_valid=0, mem_req_addr=RESET_PC, ir_valid=0, ir_data=0, ir_pc=0, busy=0, drop flag=0.
- FSM states: IDLE, REQ, WAIT, FULL.
  - IDLE: fetch_en=1 -> REQ.
  - REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready: latch req_pc=pc, pc<=pc+1, -> WAIT.
  - WAIT: on mem_rsp_valid: ir_data<=mem_rsp_data, ir_pc<=req_pc, ir_valid<=1, -> FULL.
  - FULL: on ir_ready: ir_valid<=0, then -> REQ if fetch_en, else -> IDLE.
- Latency: response in cycle N gives ir_valid=1 in N+1. With zero-wait memory and ir_ready held at 1, throughput is one instruction per 3 cycles.
- PC arithmetic: word-addressed, +1 per accepted request, modulo 2^20. 20'hFFFFF wraps to 20'h00000 silently.
- At most one request outstanding; no new request while in WAIT or FULL.
- Redirect: load_en=1 and load_select==LOAD_PC. pc<=load_data next cycle, with highest priority over all other events.
  - IDLE: pc updated, stay IDLE.
  - REQ without ready: request retargeted; next cycle mem_req_addr=load_data. Memory tolerates address change while valid.
  - REQ with mem_req_ready in the same cycle: request counts as accepted. Set drop flag, -> WAIT; pc=load_data (no +1).
  - WAIT: set drop flag, stay WAIT. If mem_rsp_valid arrives in the same cycle, that response is discarded and the unit goes -> REQ directly.
  - While the drop flag is set, the next mem_rsp_valid is discarded, the flag clears, and the unit goes -> REQ (or IDLE if fetch_en=0).
  - FULL: ir_valid<=0, -> REQ/IDLE per fetch_en. A coincident ir_ready counts as a completed handshake.
- Other load_select codes (LOAD_IR, LOAD_REG_A/B/C): ignored.
- fetch_en deassert: any in-flight request completes and the IR is delivered; the unit then parks in IDLE. fetch_en only gates new requests.
- busy = (state==WAIT) | ir_valid | drop flag.
- Reset mid-transaction: all state cleared; a response arriving after reset while in IDLE is ignored.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined: adds port stall_cnt (out, STALL_CNT_W), reset 0. It increments every cycle where (state==REQ & !mem_req_ready) or (state==WAIT & !mem_rsp_valid) or (ir_valid & !ir_ready). It saturates at all-ones and clears on rst or a redirect.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - Existing constants: WORD_SIZE, ADDR_SIZE, LOAD_PC.
  - New fetch_state_t enum {IDLE, REQ, WAIT, FULL}.
  - FETCH_RESET_PC constant used as the RESET_PC default.
- Sub-module: fetch_pc_reg (PC register with +1 wrap, load, reset), instantiated once. The FSM and IR capture stay in fetch_unit.

Test Plan:
- Basic fetch: reset, fetch_en=1, memory ready/responds next cycle with 19'h1A2B3; ir_ready=1. Expect mem_req_addr 0,1,2 on successive requests; ir_data=19'h1A2B3 with ir_pc=0; one instruction per 3 cycles.
- Decode backpressure: ir_ready=0 for 5 cycles. Expect ir_valid, ir_data and ir_pc stable, no mem_req_valid. On ir_ready=1, expect mem_req_valid next cycle.
- Redirect during WAIT: request at addr 4 accepted, then load_en=1, load_select=LOAD_PC, load_data=20'h00100 before the response. Expect the response for addr 4 discarded, ir_valid never set for it, next mem_req_addr=20'h00100.
- Wrap-around: load PC to 20'hFFFFF, fetch two words. Expect ir_pc 20'hFFFFF then 20'h00000.
- Ignored load and fetch_en drop: load_select=LOAD_REG_A with load_en=1 leaves pc unchanged. Deasserting fetch_en in WAIT still delivers the IR, then IDLE with busy=0.
- With FETCH_STALL_CNT_EN: memory withholds mem_req_ready for 3 cycles. Expect stall_cnt=3. A redirect clears it to 0.
